// File: rtl/sync_to_hs4_bridge.sv
// Synchronous source stage for a 4-phase bundled-data handshake channel.
// Words arrive on a valid/ready port and are buffered in a small FIFO.
// Each word is sent as one req/ack return-to-zero transaction.
// The returning ack is used only after it passes through a synchronizer.
//
//   state          | meaning
//   ---------------+--------------------------------------------------------
//   ST_IDLE        | no transaction open; launch when a word waits and ack_s=0
//   ST_WAIT_ACK_HI | req_o high, data_o held; wait for synchronized ack rise
//   ST_WAIT_ACK_LO | req_o low, head popped; wait for synchronized ack fall
module sync_to_hs4_bridge #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     req_o,
  output logic [DATA_W-1:0]        data_o,
  input  logic                     ack_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_ACK_HI = 2'd1,
    ST_WAIT_ACK_LO = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [SYNC_STAGES-1:0]  r_ack_sync;
  logic [FILL_W-1:0]       r_sync_fill;
  logic                    r_req;
  logic [DATA_W-1:0]       r_data;
  logic                    w_ack_s;
  logic                    w_sync_live;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_launch;

  assign w_ack_s     = r_ack_sync[SYNC_STAGES-1];
  // The synchronizer flops reset to 0, which does not mean ack is low.
  // ack_s is trusted only once every stage holds a real sample of ack_i.
  assign w_sync_live = (r_sync_fill == FILL_MAX);
  assign ready_o     = (r_count != CNT_FULL);
  assign w_push      = valid_i && ready_o;
  assign req_o       = r_req;
  assign data_o      = r_data;
  assign count_o     = r_count;
  assign busy_o      = (r_state != ST_IDLE) || (r_count != '0);

  // Shift the asynchronous ack through the synchronizer chain and track chain fill after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack_sync  <= '0;
      r_sync_fill <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_i};
      if (!w_sync_live) r_sync_fill <= r_sync_fill + FILL_W'(1);
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // FIFO pointers and occupancy; a push and a pop on the same edge leave the count unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Handshake state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode plus launch/pop strobes; an ack drop while waiting for the rise is ignored
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((r_count != '0) && !w_ack_s && w_sync_live) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_WAIT_ACK_HI;
        end
      end
      ST_WAIT_ACK_HI: begin
        if (w_ack_s) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WAIT_ACK_LO;
        end
      end
      ST_WAIT_ACK_LO: begin
        if (!w_ack_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered request and bundled data; data is loaded only on launch so it stays stable across the transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req  <= 1'b0;
      r_data <= '0;
    end else if (w_launch) begin
      r_req  <= 1'b1;
      r_data <= r_mem[r_rd_ptr];
    end else if (w_pop) begin
      r_req  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_to_hs4_bridge.sv
// Self-checking bench for sync_to_hs4_bridge: scoreboard of pushed words
// compared against data_o at every req_o rise, plus directed timing checks.
`timescale 1ns/1ps
module tb_sync_to_hs4_bridge;
  localparam int DATA_W      = 32;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;

  logic              clk_i   = 1'b0;
  logic              rst_ni  = 1'b0;
  logic              valid_i = 1'b0;
  logic [DATA_W-1:0] data_i  = '0;
  logic              ready_o;
  logic              req_o;
  logic [DATA_W-1:0] data_o;
  wire               ack_i;
  logic [2:0]        count_o;
  logic              busy_o;

  logic              auto_ack = 1'b0;
  logic              ack_man  = 1'b0;
  logic              ack_auto = 1'b0;
  logic              prev_req = 1'b0;
  logic [DATA_W-1:0] exp_q [$];
  int                n_checks = 0;
  int                n_pass   = 0;

  assign ack_i = auto_ack ? ack_auto : ack_man;

  sync_to_hs4_bridge #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .req_o(req_o), .data_o(data_o), .ack_i(ack_i),
    .count_o(count_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Instantly responding downstream: ack follows req shortly after each edge
  always begin
    @(posedge clk_i);
    #2;
    if (auto_ack) ack_auto = req_o;
  end

  // Scoreboard compare on every request rise
  always @(negedge clk_i) begin
    if (rst_ni && req_o && !prev_req) begin
      chk("sb_nonempty_on_req", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("data_order", data_o, exp_q.pop_front());
    end
    prev_req = req_o;
  end

  task automatic push_word(input logic [DATA_W-1:0] d, input int max_wait, output bit ok);
    logic ready_s;
    ok      = 1'b0;
    valid_i = 1'b1;
    data_i  = d;
    for (int i = 0; i < max_wait && !ok; i++) begin
      ready_s = ready_o;
      tick(1);
      if (ready_s) begin
        ok = 1'b1;
        exp_q.push_back(d);
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic wait_req(input logic lvl, input int max, output int cyc);
    cyc = 0;
    while (req_o !== lvl && cyc < max) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic drain(input string tag);
    int cyc;
    auto_ack = 1'b1;
    cyc = 0;
    while (busy_o !== 1'b0 && cyc < 300) begin
      tick(1);
      cyc++;
    end
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    auto_ack = 1'b0;
    ack_man  = 1'b0;
    tick(4);
  endtask

  initial begin
    bit ok;
    int cyc;
    int cnt_before;
    bit seen;

    // reset values with no clock edge
    #2;
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    tick(2);
    rst_ni = 1'b1;
    tick(6);

    // single word: latency of launch, ack rise and ack fall
    valid_i = 1'b1; data_i = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF);
    tick(1);
    valid_i = 1'b0;
    chk("sw_count_after_push", 32'(count_o), 32'd1);
    chk("sw_req_not_yet", 32'(req_o), 32'd0);
    tick(1);
    chk("sw_req_rise", 32'(req_o), 32'd1);
    chk("sw_data", data_o, 32'hDEADBEEF);
    tick(2);
    ack_man = 1'b1;
    tick(2);
    chk("sw_req_held_in_sync", 32'(req_o), 32'd1);
    tick(1);
    chk("sw_req_fall", 32'(req_o), 32'd0);
    chk("sw_count_popped", 32'(count_o), 32'd0);
    chk("sw_busy_in_ack_lo", 32'(busy_o), 32'd1);
    ack_man = 1'b0;
    tick(2);
    chk("sw_busy_before_idle", 32'(busy_o), 32'd1);
    tick(1);
    chk("sw_busy_cleared", 32'(busy_o), 32'd0);

    // full FIFO with downstream stalled
    for (int i = 1; i <= 4; i++) begin
      push_word(DATA_W'(i), 1, ok);
      chk("full_push_accepted", 32'(ok), 32'd1);
    end
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_ready_low", 32'(ready_o), 32'd0);
    push_word(32'd5, 3, ok);
    chk("full_word5_held_off", 32'(ok), 32'd0);
    chk("full_count_held", 32'(count_o), 32'd4);
    ack_man = 1'b1;
    tick(2);
    chk("full_ready_before_pop", 32'(ready_o), 32'd0);
    tick(1);
    chk("full_ready_after_pop", 32'(ready_o), 32'd1);
    chk("full_count_after_pop", 32'(count_o), 32'd3);
    ack_man  = 1'b0;
    ack_auto = 1'b0;
    auto_ack = 1'b1;
    push_word(32'd5, 20, ok);
    chk("full_word5_accepted", 32'(ok), 32'd1);
    drain("full");

    // push and pop on the same edge with two words held
    push_word(32'hA0A0_0001, 1, ok);
    push_word(32'hA0A0_0002, 1, ok);
    tick(1);
    chk("simul_req_open", 32'(req_o), 32'd1);
    chk("simul_count_pre", 32'(count_o), 32'd2);
    ack_man = 1'b1;
    tick(2);
    valid_i = 1'b1; data_i = 32'hA0A0_0003; exp_q.push_back(32'hA0A0_0003);
    tick(1);
    valid_i = 1'b0;
    chk("simul_count_same", 32'(count_o), 32'd2);
    chk("simul_req_fell", 32'(req_o), 32'd0);
    ack_man = 1'b0;
    drain("simul");

    // ten words back-to-back through a fast downstream: pointers wrap
    auto_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_word($urandom, 60, ok);
      chk("wrap_push_accepted", 32'(ok), 32'd1);
    end
    drain("wrap");

    // reset while waiting for ack rise, ack still high after release
    push_word(32'h1234_5678, 1, ok);
    wait_req(1'b1, 5, cyc);
    chk("rstmid_req_open", 32'(req_o), 32'd1);
    ack_man = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rstmid_req", 32'(req_o), 32'd0);
    chk("rstmid_data", data_o, 32'd0);
    chk("rstmid_count", 32'(count_o), 32'd0);
    chk("rstmid_ready", 32'(ready_o), 32'd1);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    exp_q.delete();
    tick(1);
    rst_ni = 1'b1;
    push_word(32'hCAFE_F00D, 1, ok);
    chk("rstmid_push_after_release", 32'(ok), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      tick(1);
      if (req_o) seen = 1'b1;
    end
    chk("rstmid_no_launch_ack_high", 32'(seen), 32'd0);
    ack_man = 1'b0;
    wait_req(1'b1, 10, cyc);
    chk("rstmid_launch_latency", 32'(cyc), 32'(SYNC_STAGES + 1));
    drain("rstmid");

    // one-cycle ack glitch while waiting for ack rise
    push_word(32'hBEEF_0001, 1, ok);
    push_word(32'hBEEF_0002, 1, ok);
    tick(1);
    cnt_before = int'(count_o);
    ack_man = 1'b1;
    tick(1);
    ack_man = 1'b0;
    tick(8);
    chk("glitch_single_pop", 32'((cnt_before - int'(count_o)) <= 1), 32'd1);
    chk("glitch_req_open", 32'(req_o), 32'd1);
    drain("glitch");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
